// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event decoder: FSM state encoding,
// default timing parameters and the counter width helper.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    PRESSED2  = 3'd4
  } state_t;

  localparam int LONG_TIME_DEF   = 50;
  localparam int DCLICK_TIME_DEF = 20;

  // Wide enough to hold the larger of the two timing limits.
  function automatic int cnt_width(input int long_time, input int dclick_time);
    int m;
    m = (long_time > dclick_time) ? long_time : dclick_time;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_detector_if.sv
// Pulse interface between the debounced button source and the event decoder.
interface button_event_detector_if;
  import button_event_pkg::*;

  // Level-in / pulse-out protocol: i_button_debounced is a level sampled on
  // every clock; every o_* event is a one-cycle pulse with no back-pressure,
  // o_held is a level, o_dbg_state mirrors the decoder FSM.
  logic   i_button_debounced;
  logic   o_held;
  logic   o_press;
  logic   o_release;
  logic   o_single_click;
  logic   o_double_click;
  logic   o_long_press;
  state_t o_dbg_state;

  modport master (
    output i_button_debounced,
    input  o_held, o_press, o_release, o_single_click,
    input  o_double_click, o_long_press, o_dbg_state
  );

  modport slave (
    input  i_button_debounced,
    output o_held, o_press, o_release, o_single_click,
    output o_double_click, o_long_press, o_dbg_state
  );

endinterface

// File: rtl/event_timer.sv
// Saturating phase counter shared by the press and gap phases: load to 1,
// increment, and flag when the count equals the current target.
module event_timer #(
  parameter int CNT_W = 6
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_hit = (r_count == i_target);

endmodule

// File: rtl/button_event_detector.sv
// Decodes a clean button level into press/release/single/double/long pulses.
// All outputs are registered; one shared timer measures hold and gap lengths.
module button_event_detector
  import button_event_pkg::*;
#(
  parameter int LONG_TIME   = LONG_TIME_DEF,
  parameter int DCLICK_TIME = DCLICK_TIME_DEF
) (
  input  logic                    aclk,
  input  logic                    arstn,
  button_event_detector_if.slave  bus
);

  localparam int CNT_W = cnt_width(LONG_TIME, DCLICK_TIME);
  // Long press fires on the edge where the count would reach LONG_TIME.
  localparam logic [CNT_W-1:0] LONG_TGT   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] DCLICK_TGT = CNT_W'(DCLICK_TIME);

  if (LONG_TIME < 2) begin : g_bad_long_time
    $error("button_event_detector: LONG_TIME must be >= 2");
  end
  if (DCLICK_TIME < 1) begin : g_bad_dclick_time
    $error("button_event_detector: DCLICK_TIME must be >= 1");
  end

  state_t           r_state;
  logic             r_btn_q;
  logic             r_press;
  logic             r_release;
  logic             r_single;
  logic             r_double;
  logic             r_long;

  logic             w_btn;
  logic             w_rise;
  logic             w_fall;
  logic             w_load;
  logic             w_inc;
  logic             w_hit;
  logic [CNT_W-1:0] w_target;

  assign w_btn  = bus.i_button_debounced;
  assign w_rise = w_btn & ~r_btn_q;
  assign w_fall = ~w_btn & r_btn_q;

  always_comb begin
    w_load   = 1'b0;
    w_inc    = 1'b0;
    w_target = LONG_TGT;
    case (r_state)
      IDLE: begin
        w_load = w_rise;
      end
      PRESSED: begin
        w_load = w_fall;
        w_inc  = ~w_fall;
      end
      PRESSED2: begin
        w_inc  = 1'b1;
      end
      GAP: begin
        w_target = DCLICK_TGT;
        w_load   = w_rise;
        w_inc    = ~w_rise;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  event_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .aclk     (aclk),
    .arstn    (arstn),
    .i_load   (w_load),
    .i_inc    (w_inc),
    .i_target (w_target),
    .o_hit    (w_hit)
  );

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state   <= IDLE;
      r_btn_q   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_btn_q   <= w_btn;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_single  <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) r_state <= PRESSED;
        end
        PRESSED: begin
          if (w_fall) begin
            r_state <= GAP;
          end else if (w_hit) begin
            r_long  <= 1'b1;
            r_state <= LONG_HELD;
          end
        end
        LONG_HELD: begin
          if (w_fall) r_state <= IDLE;
        end
        // A rise here always lands inside the window: the timeout leaves GAP first.
        GAP: begin
          if (w_rise) begin
            r_double <= 1'b1;
            r_state  <= PRESSED2;
          end else if (w_hit) begin
            r_single <= 1'b1;
            r_state  <= IDLE;
          end
        end
        PRESSED2: begin
          if (w_fall) begin
            r_state <= IDLE;
          end else if (w_hit) begin
            r_long  <= 1'b1;
            r_state <= LONG_HELD;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_held         = r_btn_q;
  assign bus.o_press        = r_press;
  assign bus.o_release      = r_release;
  assign bus.o_single_click = r_single;
  assign bus.o_double_click = r_double;
  assign bus.o_long_press   = r_long;
  assign bus.o_dbg_state    = r_state;

  a_one_click_event: assert property (
    @(posedge aclk) disable iff (!arstn) $onehot0({r_single, r_double, r_long})
  ) else $error("button_event_detector: more than one click event in a cycle");

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector: run-length reference model with a
// per-cycle scoreboard, plus literal pulse counts and edge offsets per scenario.
module tb_button_event_detector;

  localparam int LT = 50;
  localparam int DT = 20;

  logic clk;
  logic arstn;

  button_event_detector_if bus ();

  button_event_detector #(
    .LONG_TIME   (LT),
    .DCLICK_TIME (DT)
  ) dut (
    .aclk  (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Works on run lengths of high/low samples rather than on FSM states.
  logic [5:0] exp_q[$];
  int m_prev = 0, m_hi = 0, m_lo = 0, m_pending = 0, m_second = 0;

  always @(posedge clk) begin
    int b;
    logic e_press, e_rel, e_single, e_double, e_long;
    b = int'(bus.i_button_debounced);
    e_press = 0; e_rel = 0; e_single = 0; e_double = 0; e_long = 0;
    if (!arstn) begin
      m_prev = 0; m_hi = 0; m_lo = 0; m_pending = 0; m_second = 0;
      exp_q.push_back(6'b0);
    end else begin
      if (b == 1) begin
        if (m_prev == 0) begin
          e_press = 1;
          if (m_pending != 0 && m_lo >= 1 && m_lo <= DT) begin
            e_double = 1;
            m_second = 1;
          end else begin
            m_second = 0;
          end
          m_pending = 0;
          m_hi = 1;
        end else if (m_hi <= LT) begin
          m_hi = m_hi + 1;
        end
        if (m_hi == LT) e_long = 1;
        m_lo = 0;
      end else begin
        if (m_prev == 1) begin
          e_rel = 1;
          m_pending = (m_hi < LT && m_second == 0) ? 1 : 0;
          m_lo = 1;
        end else if (m_lo <= DT + 1) begin
          m_lo = m_lo + 1;
        end
        if (m_pending != 0 && m_lo == DT + 1) begin
          e_single = 1;
          m_pending = 0;
        end
        m_hi = 0;
      end
      m_prev = b;
      exp_q.push_back({b[0], e_press, e_rel, e_single, e_double, e_long});
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  logic [5:0] sb_exp, sb_act;
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      if (arstn) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: no expected entry at edge %0d", edge_cnt);
      end
    end else begin
      sb_exp = exp_q.pop_front();
      if (arstn) begin
        sb_act = {bus.o_held, bus.o_press, bus.o_release,
                  bus.o_single_click, bus.o_double_click, bus.o_long_press};
        n_tests++;
        if (sb_act !== sb_exp) begin
          n_fail++;
          $display("FAIL cycle edge %0d {held,press,rel,single,double,long}: got %b expected %b",
                   edge_cnt, sb_act, sb_exp);
        end
      end
    end
  end

  // ---------------- observation counters ----------------
  int c_press, c_rel, c_single, c_double, c_long, c_held;
  int first_press_e, last_press_e, first_rel_e, first_single_e, double_e, long_e;

  task automatic clear_counts();
    c_press = 0; c_rel = 0; c_single = 0; c_double = 0; c_long = 0; c_held = 0;
    first_press_e = -1; last_press_e = -1; first_rel_e = -1;
    first_single_e = -1; double_e = -1; long_e = -1;
  endtask

  task automatic observe();
    if (bus.o_held) c_held++;
    if (bus.o_press) begin
      c_press++;
      if (first_press_e < 0) first_press_e = edge_cnt;
      last_press_e = edge_cnt;
    end
    if (bus.o_release) begin
      c_rel++;
      if (first_rel_e < 0) first_rel_e = edge_cnt;
    end
    if (bus.o_single_click) begin
      c_single++;
      if (first_single_e < 0) first_single_e = edge_cnt;
    end
    if (bus.o_double_click) begin
      c_double++;
      double_e = edge_cnt;
    end
    if (bus.o_long_press) begin
      c_long++;
      long_e = edge_cnt;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: level v is sampled on the next n rising edges.
  task automatic hold(input logic v, input int n);
    bus.i_button_debounced = v;
    repeat (n) begin
      @(negedge clk);
      observe();
    end
  endtask

  task automatic click_pair(input int hi1, input int gap, input int hi2, input int tail);
    hold(1'b1, hi1);
    hold(1'b0, gap);
    hold(1'b1, hi2);
    hold(1'b0, tail);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int rel_e;
    arstn = 1'b0;
    bus.i_button_debounced = 1'b0;
    clear_counts();

    repeat (25) @(negedge clk);
    check("reset held",   int'(bus.o_held), 0);
    check("reset press",  int'(bus.o_press), 0);
    check("reset release", int'(bus.o_release), 0);
    check("reset single", int'(bus.o_single_click), 0);
    check("reset double", int'(bus.o_double_click), 0);
    check("reset long",   int'(bus.o_long_press), 0);
    #1 arstn = 1'b1;

    // idle after reset
    clear_counts();
    hold(1'b0, 100);
    check("idle held cycles", c_held, 0);
    check("idle events", c_press + c_rel + c_single + c_double + c_long, 0);

    // short click
    clear_counts();
    hold(1'b1, 10);
    hold(1'b0, 30);
    check("short press count", c_press, 1);
    check("short release count", c_rel, 1);
    check("short single count", c_single, 1);
    check("short single offset", first_single_e - first_rel_e, 20);
    check("short held cycles", c_held, 10);
    check("short long count", c_long, 0);
    check("short double count", c_double, 0);

    // long press
    clear_counts();
    hold(1'b1, 60);
    hold(1'b0, 30);
    check("long press count", c_press, 1);
    check("long long count", c_long, 1);
    check("long offset", long_e - first_press_e, 49);
    check("long release count", c_rel, 1);
    check("long single count", c_single, 0);

    // double click
    clear_counts();
    click_pair(5, 10, 5, 30);
    check("dbl press count", c_press, 2);
    check("dbl release count", c_rel, 2);
    check("dbl double count", c_double, 1);
    check("dbl with 2nd press", double_e, last_press_e);
    check("dbl single count", c_single, 0);

    // gap of exactly DCLICK_TIME lows
    clear_counts();
    click_pair(5, 20, 5, 30);
    check("gap20 double count", c_double, 1);
    check("gap20 single count", c_single, 0);
    check("gap20 press offset", last_press_e - first_rel_e, 20);

    // gap one longer: timeout then a fresh short click
    clear_counts();
    click_pair(5, 21, 5, 30);
    check("gap21 double count", c_double, 0);
    check("gap21 first single offset", first_single_e - first_rel_e, 20);
    check("gap21 press offset", last_press_e - first_rel_e, 21);
    check("gap21 press count", c_press, 2);
    check("gap21 single count", c_single, 2);

    // reset pulse during the gap, button held high through reset
    clear_counts();
    hold(1'b1, 5);
    hold(1'b0, 8);
    bus.i_button_debounced = 1'b1;
    #1 arstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 arstn = 1'b1;
    rel_e = edge_cnt;
    clear_counts();
    hold(1'b1, 60);
    hold(1'b0, 30);
    check("rst press edge", first_press_e - rel_e, 1);
    check("rst press count", c_press, 1);
    check("rst long offset", long_e - first_press_e, 49);
    check("rst single count", c_single, 0);
    check("rst double count", c_double, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_detector.md
Name: button_event_detector

Overview:
- Consumer-side companion of the debouncer: takes the clean, debounced button level and decodes it into single-cycle event pulses: press, release, single click, double click and long press.
- Sits directly after the debouncer in the same clock domain.
- Gives downstream logic a pulse interface, so no consumer has to re-implement edge or timing detection.

Parameters:
- LONG_TIME, 50, consecutive high samples (aclk cycles) before long_press fires; must be >= 2.
- DCLICK_TIME, 20, maximum low-gap in aclk cycles between two short presses that still forms a double click; must be >= 1.
- CNT_W, $clog2(max(LONG_TIME,DCLICK_TIME)+1), internal counter width; derived, do not override.

Ports:
- aclk  input  1  clock.
- arstn  input  1  reset, asynchronous, active-low.
- button_debounced  input  1  clean button level from the debouncer, synchronous to aclk.
- held  output  1  registered copy of the input level.
- press  output  1  one-cycle pulse on each 0->1.
- release  output  1  one-cycle pulse on each 1->0.
- single_click  output  1  one-cycle pulse when a short press is not followed by a second press in time.
- double_click  output  1  one-cycle pulse on the second press of a double click.
- long_press  output  1  one-cycle pulse once per hold reaching LONG_TIME.

Behaviour:
- Reset (arstn low, asynchronous): state IDLE, counter 0, btn_q 0, all outputs 0.
- All outputs are registered.
- Edges: rise = button_debounced & ~btn_q; fall = ~button_debounced & btn_q.
- press/release are registered at the same aclk edge where the new level is first sampled. Latency is 1 edge from a setup-met input change.
- held = btn_q.
- States:
  - IDLE: rise -> PRESSED, counter=1.
  - PRESSED: counter increments while high. At the edge where it would reach LONG_TIME, pulse long_press and go to LONG_HELD; this is edge N+LONG_TIME-1 for a press sampled at edge N. fall -> GAP, counter=1.
  - LONG_HELD: no further long_press. fall -> IDLE; no click event.
  - GAP: counter increments while low.
    - rise while counter <= DCLICK_TIME (gap of 1..DCLICK_TIME low samples) -> press and double_click in the same cycle, go to PRESSED2, counter=1.
    - Low on DCLICK_TIME+1 consecutive edges -> single_click, go to IDLE.
  - PRESSED2: same long-press timing as PRESSED; reaching LONG_TIME -> long_press, go to LONG_HELD. fall -> IDLE. A third press starts a fresh sequence from IDLE.
- Counter saturates at its maximum and never wraps.
- A rise and a timeout can never occur on the same edge, by construction of the GAP bounds.
- Press and release pulses are never suppressed, in any state.
- Reset mid-operation aborts any pending event silently; no pulse is emitted for it.
- If the button is high when arstn deasserts, press fires on the first edge (btn_q resets to 0).
- Elaboration assertion on parameter ranges; simulation assertion that at most one of single_click/double_click/long_press is high per cycle.

Decomposition:
- Package button_event_pkg holds:
  - the state enum typedef (IDLE, PRESSED, LONG_HELD, GAP, PRESSED2);
  - localparam defaults for LONG_TIME and DCLICK_TIME.
- One natural sub-module: event_timer, a saturating counter with load-to-1, increment and a compare-equal output, instantiated once and shared by the PRESSED and GAP phases.

Test Plan:
- Reset: arstn low 25 cycles, then high, button 0 for 100 cycles -> all outputs stay 0, held 0.
- Short click: button high 10 cycles, then low 30 cycles:
  - press once, release once;
  - single_click exactly 20 edges after the first low sample;
  - no long_press, no double_click.
- Long press: button high 60 cycles, then low 30 cycles:
  - press at edge N, long_press exactly at edge N+49, only once;
  - release when low;
  - no single_click.
- Double click: high 5, low 10, high 5, low 30:
  - 2 press, 2 release;
  - double_click coincident with the second press;
  - no single_click.
- Gap boundary:
  - low gap of exactly 20 cycles before the second press -> double_click;
  - repeated with a 21-cycle gap -> single_click at gap edge 21, then a plain press, no double_click.
- Reset mid-operation: arstn pulsed low during GAP with button held high through reset:
  - no single_click;
  - press fires on the first edge after reset release;
  - long_press at edge +49.
